// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter and its sequencers and pins.
// The master modport is the arbiter's view; slave is the sequencer/pin side.
interface sdram_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2
);
  logic                 init_done;
  logic [3:0]           init_cmd;
  logic [ADDR_BITS-1:0] init_addr;
  logic [BA_BITS-1:0]   init_ba;
  logic [3:0]           aref_cmd;
  logic [ADDR_BITS-1:0] aref_addr;
  logic [BA_BITS-1:0]   aref_ba;
  logic [3:0]           wr_cmd;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [BA_BITS-1:0]   wr_ba;
  logic [3:0]           rd_cmd;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [BA_BITS-1:0]   rd_ba;
  logic                 aref_done;
  logic                 wr_req;
  logic                 wr_done;
  logic                 rd_req;
  logic                 rd_done;
  logic                 aref_en;
  logic                 wr_en;
  logic                 rd_en;
  logic                 wr_break;
  logic                 rd_break;
  logic                 ref_overrun;
  logic [3:0]           sdram_cmd;
  logic [ADDR_BITS-1:0] sdram_addr;
  logic [BA_BITS-1:0]   sdram_ba;

  modport master (
    input  init_done,
    input  init_cmd, init_addr, init_ba,
    input  aref_cmd, aref_addr, aref_ba,
    input  wr_cmd, wr_addr, wr_ba,
    input  rd_cmd, rd_addr, rd_ba,
    input  aref_done, wr_req, wr_done, rd_req, rd_done,
    output aref_en, wr_en, rd_en, wr_break, rd_break, ref_overrun,
    output sdram_cmd, sdram_addr, sdram_ba
  );

  modport slave (
    output init_done,
    output init_cmd, init_addr, init_ba,
    output aref_cmd, aref_addr, aref_ba,
    output wr_cmd, wr_addr, wr_ba,
    output rd_cmd, rd_addr, rd_ba,
    output aref_done, wr_req, wr_done, rd_req, rd_done,
    input  aref_en, wr_en, rd_en, wr_break, rd_break, ref_overrun,
    input  sdram_cmd, sdram_addr, sdram_ba
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: init/refresh/write/read ownership, refresh timer and command mux.
// Define ARB_ROUND_ROBIN_EN to alternate write/read when both request at once.
module sdram_arbiter #(
  parameter int REF_CYCLES = 1040,
  parameter int REF_WIDTH  = 11,
  parameter int ADDR_BITS  = 12,
  parameter int BA_BITS    = 2
) (
  input logic             sys_clk,
  input logic             sys_rst,
  sdram_arbiter_if.master bus
);

  typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;

  localparam logic [REF_WIDTH-1:0] REF_LAST = REF_WIDTH'(REF_CYCLES - 1);
  localparam logic [3:0]           CMD_NOP  = 4'b0111;

  state_t               state;
  state_t               state_nxt;
  logic [REF_WIDTH-1:0] ref_cnt;
  logic                 ref_pend;
  logic                 ref_pend_nxt;
  logic                 ref_tc;
  logic                 aref_entry;
  logic                 pick_wr;
  logic                 pick_rd;
  logic                 aref_en;
  logic                 wr_en;
  logic                 rd_en;
  logic                 wr_break;
  logic                 rd_break;
  logic                 ref_overrun;

  // Timer is frozen at zero until initialization has finished.
  assign ref_tc = (state != INIT) && (ref_cnt == REF_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_rw;  // 0: write granted last, 1: read granted last

  always_comb begin
    pick_wr = bus.wr_req && (!bus.rd_req || last_rw);
    pick_rd = bus.rd_req && (!bus.wr_req || !last_rw);
  end
`else
  always_comb begin
    pick_wr = bus.wr_req;
    pick_rd = bus.rd_req && !bus.wr_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:  if (bus.init_done) state_nxt = IDLE;
      IDLE: begin
        if (ref_pend)     state_nxt = AREF;
        else if (pick_wr) state_nxt = WRITE;
        else if (pick_rd) state_nxt = READ;
      end
      AREF:  if (bus.aref_done) state_nxt = IDLE;
      WRITE: if (bus.wr_done)   state_nxt = IDLE;
      READ:  if (bus.rd_done)   state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // A pending refresh is consumed when AREF is entered; otherwise expiry sets it.
  always_comb begin
    aref_entry   = (state != AREF) && (state_nxt == AREF);
    ref_pend_nxt = ref_pend;
    if (aref_entry)  ref_pend_nxt = 1'b0;
    else if (ref_tc) ref_pend_nxt = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= INIT;
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      wr_break    <= 1'b0;
      rd_break    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_rw     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ref_pend <= ref_pend_nxt;
      if (state == INIT || ref_tc) ref_cnt <= '0;
      else                         ref_cnt <= ref_cnt + 1'b1;
      if (ref_tc && ref_pend && !aref_entry) ref_overrun <= 1'b1;
      // Grants and breaks are decoded from the next state so they align with it.
      aref_en  <= (state_nxt == AREF);
      wr_en    <= (state_nxt == WRITE);
      rd_en    <= (state_nxt == READ);
      wr_break <= (state_nxt == WRITE) && ref_pend_nxt;
      rd_break <= (state_nxt == READ) && ref_pend_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      if (state == IDLE && state_nxt == WRITE) last_rw <= 1'b0;
      if (state == IDLE && state_nxt == READ)  last_rw <= 1'b1;
`endif
    end
  end

  always_comb begin
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_addr = '0;
    bus.sdram_ba   = '0;
    unique case (state)
      INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
        bus.sdram_ba   = bus.init_ba;
      end
      AREF: begin
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_addr = bus.aref_addr;
        bus.sdram_ba   = bus.aref_ba;
      end
      WRITE: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_ba   = bus.wr_ba;
      end
      READ: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_ba   = bus.rd_ba;
      end
      default: begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = '0;
        bus.sdram_ba   = '0;
      end
    endcase
  end

  assign bus.aref_en     = aref_en;
  assign bus.wr_en       = wr_en;
  assign bus.rd_en       = rd_en;
  assign bus.wr_break    = wr_break;
  assign bus.rd_break    = rd_break;
  assign bus.ref_overrun = ref_overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed-plus-random bench for sdram_arbiter against an ownership/timing reference model.
module tb_sdram_arbiter;
  localparam int RC = 20;
  localparam int RW = 5;
  localparam int AB = 12;
  localparam int BB = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  sdram_arbiter_if #(.ADDR_BITS(AB), .BA_BITS(BB)) ifc();

  sdram_arbiter #(.REF_CYCLES(RC), .REF_WIDTH(RW), .ADDR_BITS(AB), .BA_BITS(BB)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (ifc.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, cycles since init finished, refresh debt.
  byte m_own;
  int  m_age;
  int  m_dwell;
  bit  m_pend;
  bit  m_ovr;
  bit  m_last_rd;

  int  aref_len, wr_len, rd_len;
  bit  stray;
  bit  force_wr_done;
  bit  prev_wr, prev_rd;
  byte seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = "I"; m_age = 0; m_dwell = 0;
    m_pend = 1'b0; m_ovr = 1'b0; m_last_rd = 1'b0;
  endtask

  task automatic model_edge();
    bit  due, enter_a, win_w;
    byte nxt;
    due     = (m_own != "I") && ((m_age % RC) == RC - 1);
    enter_a = 1'b0;
    nxt     = m_own;
`ifdef ARB_ROUND_ROBIN_EN
    win_w = ifc.wr_req && (!ifc.rd_req || m_last_rd);
`else
    win_w = ifc.wr_req;
`endif
    case (m_own)
      "I": if (ifc.init_done) nxt = "-";
      "-": begin
        if (m_pend) begin nxt = "A"; enter_a = 1'b1; end
        else if (win_w) nxt = "W";
        else if (ifc.rd_req) nxt = "R";
      end
      "A": if (ifc.aref_done) nxt = "-";
      "W": if (ifc.wr_done) nxt = "-";
      "R": if (ifc.rd_done) nxt = "-";
      default: nxt = "I";
    endcase
    if (due && m_pend && !enter_a) m_ovr = 1'b1;
    if (enter_a) m_pend = 1'b0;
    else if (due) m_pend = 1'b1;
    m_age   = (m_own == "I") ? 0 : m_age + 1;
    m_dwell = (nxt != m_own) ? 0 : m_dwell + 1;
    if (m_own == "-" && nxt == "W") m_last_rd = 1'b0;
    if (m_own == "-" && nxt == "R") m_last_rd = 1'b1;
    m_own = nxt;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_g, obs_g, exp_b, obs_b;
    exp_g = {26'b0, m_own == "A", m_own == "W", m_own == "R",
             (m_own == "W") && m_pend, (m_own == "R") && m_pend, m_ovr};
    obs_g = {26'b0, ifc.aref_en, ifc.wr_en, ifc.rd_en, ifc.wr_break, ifc.rd_break, ifc.ref_overrun};
    case (m_own)
      "I":     exp_b = {14'b0, ifc.init_cmd, ifc.init_addr, ifc.init_ba};
      "A":     exp_b = {14'b0, ifc.aref_cmd, ifc.aref_addr, ifc.aref_ba};
      "W":     exp_b = {14'b0, ifc.wr_cmd, ifc.wr_addr, ifc.wr_ba};
      "R":     exp_b = {14'b0, ifc.rd_cmd, ifc.rd_addr, ifc.rd_ba};
      default: exp_b = {14'b0, 4'b0111, 12'b0, 2'b0};
    endcase
    obs_b = {14'b0, ifc.sdram_cmd, ifc.sdram_addr, ifc.sdram_ba};
    chk("grants_breaks_overrun", obs_g, exp_g);
    chk("bus_mux", obs_b, exp_b);
  endtask

  task automatic cycle();
    ifc.init_cmd  = 4'($urandom); ifc.init_addr = AB'($urandom); ifc.init_ba = BB'($urandom);
    ifc.aref_cmd  = 4'($urandom); ifc.aref_addr = AB'($urandom); ifc.aref_ba = BB'($urandom);
    ifc.wr_cmd    = 4'($urandom); ifc.wr_addr   = AB'($urandom); ifc.wr_ba   = BB'($urandom);
    ifc.rd_cmd    = 4'($urandom); ifc.rd_addr   = AB'($urandom); ifc.rd_ba   = BB'($urandom);
    ifc.aref_done = (m_own == "A" && m_dwell == aref_len - 1) ||
                    (stray && m_own != "A" && $urandom_range(0, 7) == 0);
    ifc.wr_done   = (m_own == "W" && m_dwell == wr_len - 1) || force_wr_done ||
                    (stray && m_own != "W" && $urandom_range(0, 7) == 0);
    ifc.rd_done   = (m_own == "R" && m_dwell == rd_len - 1) ||
                    (stray && m_own != "R" && $urandom_range(0, 7) == 0);
    @(posedge sys_clk);
    model_edge();
    #1;
    check_outputs();
    if (ifc.wr_en && !prev_wr) seq.push_back("W");
    if (ifc.rd_en && !prev_rd) seq.push_back("R");
    prev_wr = ifc.wr_en;
    prev_rd = ifc.rd_en;
  endtask

  initial begin
    int  cnt;
    byte exp_seq[3];

    ifc.init_done = 1'b0; ifc.wr_req = 1'b0; ifc.rd_req = 1'b0;
    ifc.aref_done = 1'b0; ifc.wr_done = 1'b0; ifc.rd_done = 1'b0;
    ifc.init_cmd = 4'hA; ifc.init_addr = 12'h5C3; ifc.init_ba = 2'd2;
    ifc.aref_cmd = '0; ifc.aref_addr = '0; ifc.aref_ba = '0;
    ifc.wr_cmd = '0; ifc.wr_addr = '0; ifc.wr_ba = '0;
    ifc.rd_cmd = '0; ifc.rd_addr = '0; ifc.rd_ba = '0;
    aref_len = 8; wr_len = 0; rd_len = 0; stray = 1'b0; force_wr_done = 1'b0;
    prev_wr = 1'b0; prev_rd = 1'b0;

    // Reset state
    sys_rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    #2 sys_rst = 1'b0;

    // Held in INIT: requests must not be granted, bus follows init_*
    for (int i = 0; i < 50; i++) begin
      ifc.wr_req = 1'($urandom); ifc.rd_req = 1'($urandom);
      cycle();
    end
    ifc.wr_req = 1'b0; ifc.rd_req = 1'b0;

    ifc.init_done = 1'b1;
    cycle();
    chk("idle_nop_after_init", {28'b0, ifc.sdram_cmd}, 32'h7);

    // First refresh falls RC+1 edges after entering IDLE
    cnt = 0;
    do begin cycle(); cnt++; end while (!ifc.aref_en && cnt < 100);
    chk("first_aref_latency", cnt, RC + 1);
    for (int i = 0; i < 70; i++) cycle();
    chk("no_overrun_idle", {31'b0, ifc.ref_overrun}, 32'h0);

    // Write grant, then break on refresh expiry, done 3 cycles later
    cnt = 0;
    while ((m_own != "-" || m_pend) && cnt < 50) begin cycle(); cnt++; end
    ifc.wr_req = 1'b1;
    cycle();
    chk("wr_en_next_edge", {31'b0, ifc.wr_en}, 32'h1);
    ifc.wr_req = 1'b0;
    cnt = 0;
    while (!ifc.wr_break && cnt < 40) begin cycle(); cnt++; end
    chk("wr_break_seen", {31'b0, ifc.wr_break}, 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    force_wr_done = 1'b1;
    cycle();
    force_wr_done = 1'b0;
    chk("idle_after_wr_done", {29'b0, ifc.aref_en, ifc.wr_en, ifc.rd_en}, 32'h0);
    cycle();
    chk("aref_after_break", {31'b0, ifc.aref_en}, 32'h1);
    for (int i = 0; i < 10; i++) cycle();

    // Both requesters held high
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = m_last_rd ? "W" : "R";
    exp_seq[1] = (exp_seq[0] == "W") ? "R" : "W";
    exp_seq[2] = exp_seq[0];
`else
    exp_seq[0] = "W"; exp_seq[1] = "W"; exp_seq[2] = "W";
`endif
    seq.delete();
    wr_len = 5; rd_len = 5;
    ifc.wr_req = 1'b1; ifc.rd_req = 1'b1;
    cnt = 0;
    while (seq.size() < 3 && cnt < 200) begin cycle(); cnt++; end
    ifc.wr_req = 1'b0; ifc.rd_req = 1'b0;
    if (seq.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("grant_seq_%0d", i), seq[i], exp_seq[i]);
    end else begin
      chk("grant_seq_timeout", seq.size(), 3);
    end
    for (int i = 0; i < 8; i++) cycle();

    // Write held for 45 cycles: second expiry flags overrun
    wr_len = 0;
    cnt = 0;
    while (m_own != "-" && cnt < 50) begin cycle(); cnt++; end
    ifc.wr_req = 1'b1;
    cnt = 0;
    do begin cycle(); cnt++; end while (!ifc.wr_en && cnt < 50);
    ifc.wr_req = 1'b0;
    for (int i = 0; i < 45; i++) cycle();
    chk("overrun_set", {31'b0, ifc.ref_overrun}, 32'h1);
    force_wr_done = 1'b1;
    cycle();
    force_wr_done = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("overrun_sticky", {31'b0, ifc.ref_overrun}, 32'h1);
    for (int i = 0; i < 12; i++) cycle();

    // Reset in the middle of a read
    rd_len = 0;
    ifc.rd_req = 1'b1;
    cnt = 0;
    while (m_own != "R" && cnt < 80) begin cycle(); cnt++; end
    cycle(); cycle();
    #2 sys_rst = 1'b1;
    model_reset();
    #1;
    chk("rd_en_async_clear", {31'b0, ifc.rd_en}, 32'h0);
    check_outputs();
    #1 sys_rst = 1'b0;
    ifc.rd_req = 1'b0;
    cycle();
    chk("idle_nop_after_reset", {28'b0, ifc.sdram_cmd}, 32'h7);
    cnt = 0;
    do begin cycle(); cnt++; end while (!ifc.aref_en && cnt < 100);
    chk("aref_latency_after_reset", cnt, RC + 1);

    // Random traffic with stray done pulses
    aref_len = $urandom_range(1, 6); wr_len = $urandom_range(1, 6); rd_len = $urandom_range(1, 6);
    stray = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ifc.wr_req = ~ifc.wr_req;
      if ($urandom_range(0, 3) == 0) ifc.rd_req = ~ifc.rd_req;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
